// File: rtl/stopwatch_sequencer.sv
// -----------------------------------------------------------------------------
// stopwatch_sequencer
//
// Button front-end and control sequencer for the stopwatch. Each raw button is
// synchronised, debounced on the tick strobe and turned into a single-clk
// press pulse on its debounced rising edge. The press pulses drive a 4-state
// Moore FSM whose registered outputs enable the time counter, freeze the
// display for lap readings and pulse a counter clear.
//
// Parameters
//   DEBOUNCE_TICKS  consecutive ticks at a new level before the debounced
//                   level follows (1..15)
//   SYNC_STAGES     synchroniser depth per button (>= 2)
//
// Ports
//   clk             system clock
//   res             synchronous active-high reset
//   tick            one-clk sample strobe for the debouncers
//   btn_start_stop  raw start/stop button, active-high, asynchronous
//   btn_lap_reset   raw lap/reset button, active-high, asynchronous
//   counter_enable  time counter counts while high
//   counter_clear   one-clk pulse zeroing the time counter
//   display_enable  display tracks the counter while high, frozen when low
//   lap_count[3:0]  saturating count of RUNNING->LAP entries
//                   (present only when SEQ_LAP_COUNT_EN is defined)
//   state[1:0]      current FSM state code (debug)
//
// Build option
//   SEQ_LAP_COUNT_EN  define to add the lap_count output and its counter.
// -----------------------------------------------------------------------------
module stopwatch_sequencer #(
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       res,
  input  logic       tick,
  input  logic       btn_start_stop,
  input  logic       btn_lap_reset,
  output logic       counter_enable,
  output logic       counter_clear,
  output logic       display_enable,
`ifdef SEQ_LAP_COUNT_EN
  output logic [3:0] lap_count,
`endif
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    LAP     = 2'b10,
    STOPPED = 2'b11
  } state_e;

  // Counter value on which the next differing tick completes the debounce.
  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_TICKS - 1);

  // Bit 0: start/stop, bit 1: lap/reset.
  logic [1:0] raw;
  logic [1:0] press;

  assign raw = {btn_lap_reset, btn_start_stop};

  // ---------------------------------------------------------------------------
  // Per-button synchroniser, debouncer and press-pulse generator
  // ---------------------------------------------------------------------------
  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [3:0]             cnt_q, cnt_d;
    logic                   deb_q, deb_d;
    logic                   deb_prev_q;
    logic                   press_q;

    assign synced = sync_q[SYNC_STAGES-1];

    // The counter only measures an unbroken run of ticks at the new level;
    // any tick that sees the levels agree restarts the run.
    always_comb begin
      deb_d = deb_q;
      cnt_d = cnt_q;
      if (tick) begin
        if (synced != deb_q) begin
          if (cnt_q == DB_LAST) begin
            deb_d = synced;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          cnt_d = '0;
        end
      end
    end

    // The press pulse is taken from the registered debounced level, so it
    // appears one clk after the flip and lasts exactly one clk.
    always_ff @(posedge clk) begin
      if (res) begin
        sync_q     <= '0;
        cnt_q      <= '0;
        deb_q      <= 1'b0;
        deb_prev_q <= 1'b0;
        press_q    <= 1'b0;
      end else begin
        sync_q     <= {sync_q[SYNC_STAGES-2:0], raw[b]};
        cnt_q      <= cnt_d;
        deb_q      <= deb_d;
        deb_prev_q <= deb_q;
        press_q    <= deb_q & ~deb_prev_q;
      end
    end

    assign press[b] = press_q;
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  logic   start_ev;
  logic   lap_ev;
  state_e state_q, state_d;
  logic   clear_d, clear_q;
  logic   enable_q;
  logic   display_q;

  assign start_ev = press[0];
  assign lap_ev   = press[1];

  // start_ev is tested first in every state, so a lap pulse arriving in the
  // same clk is dropped.
  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ev) begin
          state_d = RUNNING;
        end else if (lap_ev) begin
          state_d = IDLE;
          clear_d = 1'b1;
        end
      end
      RUNNING: begin
        if (start_ev) begin
          state_d = STOPPED;
        end else if (lap_ev) begin
          state_d = LAP;
        end
      end
      LAP: begin
        if (start_ev) begin
          state_d = STOPPED;
        end else if (lap_ev) begin
          state_d = RUNNING;
        end
      end
      STOPPED: begin
        if (start_ev) begin
          state_d = RUNNING;
        end else if (lap_ev) begin
          state_d = IDLE;
          clear_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state register and always match its decode.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= IDLE;
      enable_q  <= 1'b0;
      display_q <= 1'b1;
      clear_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      enable_q  <= (state_d == RUNNING) || (state_d == LAP);
      display_q <= (state_d != LAP);
      clear_q   <= clear_d;
    end
  end

`ifdef SEQ_LAP_COUNT_EN
  logic [3:0] lap_cnt_q, lap_cnt_d;

  always_comb begin
    lap_cnt_d = lap_cnt_q;
    if (clear_d) begin
      lap_cnt_d = '0;
    end else if ((state_q == RUNNING) && (state_d == LAP) && (lap_cnt_q != 4'hF)) begin
      lap_cnt_d = lap_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      lap_cnt_q <= '0;
    end else begin
      lap_cnt_q <= lap_cnt_d;
    end
  end

  assign lap_count = lap_cnt_q;
`endif

  assign state          = state_q;
  assign counter_enable = enable_q;
  assign display_enable = display_q;
  assign counter_clear  = clear_q;

endmodule

// File: tb/tb_stopwatch_sequencer.sv
module tb_stopwatch_sequencer;

  localparam int DT = 4;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       tick = 1'b0;
  logic       bs = 1'b0;
  logic       bl = 1'b0;
  logic       counter_enable;
  logic       counter_clear;
  logic       display_enable;
  logic [1:0] state;
`ifdef SEQ_LAP_COUNT_EN
  logic [3:0] lap_count;
`endif

  stopwatch_sequencer #(
    .DEBOUNCE_TICKS (DT),
    .SYNC_STAGES    (SS)
  ) dut (
    .clk            (clk),
    .res            (res),
    .tick           (tick),
    .btn_start_stop (bs),
    .btn_lap_reset  (bl),
    .counter_enable (counter_enable),
    .counter_clear  (counter_clear),
    .display_enable (display_enable),
`ifdef SEQ_LAP_COUNT_EN
    .lap_count      (lap_count),
`endif
    .state          (state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit rand_tick = 0;

  // ---------------------------------------------------------------------------
  // Reference model: raw-level delay lines, tick-run debounce rule, a fixed
  // two-clk event delay from debounced rise to state change, and table-driven
  // state transitions.
  // ---------------------------------------------------------------------------
  bit sq_s[$], sq_l[$];
  bit eq_s[$], eq_l[$];
  int m_cnt_s, m_cnt_l;
  bit m_deb_s, m_deb_l;
  int m_st;
  bit m_clr;
  int m_lapc;

  int nxt_start [4] = '{1, 3, 3, 1};
  int nxt_lap   [4] = '{0, 2, 1, 0};
  bit en_tab    [4] = '{0, 1, 1, 0};
  bit disp_tab  [4] = '{1, 1, 0, 1};

  task automatic model_reset();
    sq_s.delete(); sq_l.delete(); eq_s.delete(); eq_l.delete();
    for (int i = 0; i < SS; i++) begin
      sq_s.push_back(1'b0);
      sq_l.push_back(1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      eq_s.push_back(1'b0);
      eq_l.push_back(1'b0);
    end
    m_cnt_s = 0; m_cnt_l = 0; m_deb_s = 0; m_deb_l = 0;
    m_st = 0; m_clr = 0; m_lapc = 0;
  endtask

  task automatic deb_rule(input bit synced, inout int cnt, inout bit deb, output bit rose);
    rose = 1'b0;
    if (!tick) return;
    if (synced == deb) begin
      cnt = 0;
      return;
    end
    cnt++;
    if (cnt == DT) begin
      deb  = synced;
      cnt  = 0;
      rose = synced;
    end
  endtask

  task automatic model_edge();
    bit es, el, rs, rl, ys, yl;
    int nx;
    if (res) begin
      model_reset();
      return;
    end
    es = eq_s.pop_front();
    el = eq_l.pop_front();
    m_clr = 1'b0;
    if (es) begin
      m_st = nxt_start[m_st];
    end else if (el) begin
      nx = nxt_lap[m_st];
      if (m_st == 0 || m_st == 3) m_clr = 1'b1;
      if (m_st == 1 && nx == 2 && m_lapc < 15) m_lapc++;
      m_st = nx;
    end
    if (m_clr) m_lapc = 0;
    ys = sq_s.pop_front(); sq_s.push_back(bs);
    yl = sq_l.pop_front(); sq_l.push_back(bl);
    deb_rule(ys, m_cnt_s, m_deb_s, rs);
    deb_rule(yl, m_cnt_l, m_deb_l, rl);
    eq_s.push_back(rs);
    eq_l.push_back(rl);
  endtask

  function automatic logic [8:0] exp_vec();
`ifdef SEQ_LAP_COUNT_EN
    return {4'(m_lapc), 2'(m_st), en_tab[m_st], disp_tab[m_st], m_clr};
`else
    return {4'h0, 2'(m_st), en_tab[m_st], disp_tab[m_st], m_clr};
`endif
  endfunction

  function automatic logic [8:0] obs_vec();
`ifdef SEQ_LAP_COUNT_EN
    return {lap_count, state, counter_enable, display_enable, counter_clear};
`else
    return {4'h0, state, counter_enable, display_enable, counter_clear};
`endif
  endfunction

  // One clk: model follows the edge, outputs settle, next tick value driven.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    tick = rand_tick ? 1'($urandom_range(0, 1)) : 1'(cyc % 2);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    res = 1'b1; bs = 1'b0; bl = 1'b0;
    repeat (3) begin
      step();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if (state !== 2'b00 || counter_enable !== 1'b0 || display_enable !== 1'b1 || counter_clear !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values got st=%b en=%b disp=%b clr=%b exp st=00 en=0 disp=1 clr=0",
               state, counter_enable, display_enable, counter_clear);
    end
    res = 1'b0;
  endtask

  task automatic test_start();
    bs = 1'b1;
    repeat (16) begin
      step();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL start_press cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if (state !== 2'b01 || counter_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL start_running got st=%b en=%b exp st=01 en=1", state, counter_enable);
    end
    repeat (20) begin
      step();
      n_tests++;
      if (obs_vec() !== exp_vec() || state !== 2'b01) begin
        n_fail++;
        $display("FAIL start_hold cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    bs = 1'b0;
    repeat (16) begin
      step();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL start_release cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_lap();
    logic [1:0] exp_st [2] = '{2'b10, 2'b01};
    logic       exp_dp [2] = '{1'b0, 1'b1};
    for (int p = 0; p < 2; p++) begin
      bl = 1'b1;
      repeat (16) begin
        step();
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++;
          $display("FAIL lap_press cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
        end
      end
      bl = 1'b0;
      repeat (16) begin
        step();
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++;
          $display("FAIL lap_release cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
        end
      end
      n_tests++;
      if (state !== exp_st[p] || display_enable !== exp_dp[p] || counter_enable !== 1'b1) begin
        n_fail++;
        $display("FAIL lap_state%0d got st=%b disp=%b en=%b exp st=%b disp=%b en=1",
                 p, state, display_enable, counter_enable, exp_st[p], exp_dp[p]);
      end
    end
  endtask

  task automatic test_stop_clear();
    int  clr_seen;
    bit  saw_lap;
    // start -> STOPPED
    bs = 1'b1;
    repeat (16) begin
      step();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL stop_press cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    bs = 1'b0;
    repeat (16) begin
      step();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL stop_release cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if (state !== 2'b11 || counter_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_state got st=%b en=%b exp st=11 en=0", state, counter_enable);
    end
    // lap from STOPPED -> IDLE with one clear pulse
    clr_seen = 0;
    bl = 1'b1;
    repeat (32) begin
      if (cyc % 32 == 16) bl = 1'b0;
      step();
      if (counter_clear === 1'b1) clr_seen++;
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL clear_press cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    bl = 1'b0;
    repeat (16) begin
      step();
      if (counter_clear === 1'b1) clr_seen++;
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL clear_release cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if (state !== 2'b00 || clr_seen != 1) begin
      n_fail++;
      $display("FAIL clear_pulse got st=%b clr_cycles=%0d exp st=00 clr_cycles=1", state, clr_seen);
    end
    // back to RUNNING, then simultaneous presses
    bs = 1'b1;
    repeat (16) begin
      step();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL rerun_press cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    bs = 1'b0;
    repeat (16) begin
      step();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL rerun_release cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    saw_lap = 1'b0;
    bs = 1'b1; bl = 1'b1;
    repeat (16) begin
      step();
      if (state === 2'b10) saw_lap = 1'b1;
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL simul_press cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    bs = 1'b0; bl = 1'b0;
    repeat (16) begin
      step();
      if (state === 2'b10) saw_lap = 1'b1;
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL simul_release cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if (state !== 2'b11 || saw_lap) begin
      n_fail++;
      $display("FAIL simul_priority got st=%b saw_lap=%0d exp st=11 saw_lap=0", state, saw_lap);
    end
  endtask

  task automatic test_bounce();
    // Start from a fresh IDLE.
    res = 1'b1;
    step();
    res = 1'b0;
    // Toggle every 2 ticks (4 clks with the periodic tick) for 20 ticks.
    for (int k = 0; k < 10; k++) begin
      bs = (k % 2 == 0);
      repeat (4) begin
        step();
        n_tests++;
        if (obs_vec() !== exp_vec() || state !== 2'b00) begin
          n_fail++;
          $display("FAIL bounce cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
        end
      end
    end
    bs = 1'b0;
    repeat (12) begin
      step();
      n_tests++;
      if (obs_vec() !== exp_vec() || state !== 2'b00) begin
        n_fail++;
        $display("FAIL bounce_settle cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    bs = 1'b1;
    repeat (16) begin
      step();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL bounce_clean cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    bs = 1'b0;
    repeat (16) begin
      step();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL bounce_release cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if (state !== 2'b01) begin
      n_fail++;
      $display("FAIL bounce_then_run got st=%b exp st=01", state);
    end
  endtask

  task automatic test_mid_reset();
    int guard;
    int clr_seen;
    // RUNNING -> LAP
    bl = 1'b1;
    repeat (16) begin
      step();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL midrst_lap cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    bl = 1'b0;
    repeat (16) begin
      step();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL midrst_lap_rel cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    // Press lap again and reset once its debounce run has reached 2 ticks.
    bl = 1'b1;
    guard = 0;
    while (m_cnt_l != 2 && guard < 40) begin
      step();
      guard++;
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL midrst_wait cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if (guard >= 40 || state !== 2'b10) begin
      n_fail++;
      $display("FAIL midrst_setup got st=%b waited=%0d exp st=10 waited<40", state, guard);
    end
    res = 1'b1;
    step();
    res = 1'b0;
    n_tests++;
    if (state !== 2'b00 || display_enable !== 1'b1 || counter_enable !== 1'b0 || counter_clear !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_values got st=%b en=%b disp=%b clr=%b exp st=00 en=0 disp=1 clr=0",
               state, counter_enable, display_enable, counter_clear);
    end
    // Button still held: it is seen as a fresh lap press from IDLE.
    clr_seen = 0;
    repeat (20) begin
      step();
      if (counter_clear === 1'b1) clr_seen++;
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL midrst_held cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    bl = 1'b0;
    repeat (16) begin
      step();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL midrst_release cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if (clr_seen != 1 || state !== 2'b00) begin
      n_fail++;
      $display("FAIL midrst_held_press got clr_cycles=%0d st=%b exp clr_cycles=1 st=00", clr_seen, state);
    end
  endtask

`ifdef SEQ_LAP_COUNT_EN
  task automatic test_lap_count();
    // IDLE: start, 34 lap presses (17 LAP entries), start, lap.
    for (int p = 0; p < 38; p++) begin
      if (p == 0 || p == 35) begin
        bs = 1'b1;
      end else if (p == 36) begin
        bl = 1'b1;
      end else if (p < 35) begin
        bl = 1'b1;
      end
      repeat (16) begin
        step();
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++;
          $display("FAIL lapcnt_press cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
        end
      end
      bs = 1'b0; bl = 1'b0;
      repeat (16) begin
        step();
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
          n_fail++;
          $display("FAIL lapcnt_release cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
        end
      end
      if (p == 34) begin
        n_tests++;
        if (lap_count !== 4'd15 || state !== 2'b01) begin
          n_fail++;
          $display("FAIL lapcnt_saturate got cnt=%0d st=%b exp cnt=15 st=01", lap_count, state);
        end
      end
    end
    n_tests++;
    if (lap_count !== 4'd0 || state !== 2'b00) begin
      n_fail++;
      $display("FAIL lapcnt_clear got cnt=%0d st=%b exp cnt=0 st=00", lap_count, state);
    end
  endtask
`endif

  task automatic test_random();
    rand_tick = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 23) == 0) bs = ~bs;
      if ($urandom_range(0, 23) == 0) bl = ~bl;
      res = ($urandom_range(0, 299) == 0);
      step();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
    end
    res = 1'b0;
    rand_tick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start();
    test_lap();
    test_stop_clear();
    test_bounce();
    test_mid_reset();
`ifdef SEQ_LAP_COUNT_EN
    test_lap_count();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
